// File: rtl/multicycle_sequencer_pkg.sv
// Shared control types for the multi-cycle RV64 sequencer: selects, trap causes,
// sequencer states, opcode classes and the opcode classifier.
package multicycle_sequencer_pkg;

    typedef enum logic {ALU_SRC_REG = 1'b0, ALU_SRC_IMM = 1'b1} Alu_Src_t;
    typedef enum logic {REG_SRC_ALU = 1'b0, REG_SRC_MEM = 1'b1} Reg_Src_t;

    typedef enum logic [1:0] {
        TRAP_NONE    = 2'b00,
        TRAP_ILLEGAL = 2'b01,
        TRAP_TIMEOUT = 2'b10
    } Trap_Cause_t;

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEM       = 3'd3,
        WRITEBACK = 3'd4,
        HALT      = 3'd5,
        TRAP      = 3'd6
    } Seq_State_t;

    typedef enum logic [2:0] {
        CLS_NONE   = 3'd0,
        CLS_R      = 3'd1,
        CLS_I      = 3'd2,
        CLS_LOAD   = 3'd3,
        CLS_STORE  = 3'd4,
        CLS_BRANCH = 3'd5
    } Op_Class_t;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef struct packed {
        logic      legal;
        Op_Class_t cls;
        Alu_Src_t  alu_src;
        Reg_Src_t  reg_src;
    } Decode_t;

    function automatic Decode_t decode_opcode(input logic [6:0] opc);
        Decode_t d;
        d.legal   = 1'b1;
        d.cls     = CLS_NONE;
        d.alu_src = ALU_SRC_REG;
        d.reg_src = REG_SRC_ALU;
        case (opc)
            OPC_R:      d.cls = CLS_R;
            OPC_I:      begin d.cls = CLS_I;     d.alu_src = ALU_SRC_IMM; end
            OPC_LOAD:   begin d.cls = CLS_LOAD;  d.alu_src = ALU_SRC_IMM; d.reg_src = REG_SRC_MEM; end
            OPC_STORE:  begin d.cls = CLS_STORE; d.alu_src = ALU_SRC_IMM; end
            OPC_BRANCH: d.cls = CLS_BRANCH;
            default:    d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/multicycle_sequencer_timeout_counter.sv
// Counts consecutive stalled memory-wait cycles; expired_out pulses on the
// MEM_TIMEOUT-th stalled cycle.
module seq_timeout_counter
    import multicycle_sequencer_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk_in,
    input  logic reset,
    input  logic enable_in,
    input  logic clear_in,
    output logic expired_out
);

    localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

    logic [CW-1:0] count_q;

    assign expired_out = enable_in && (count_q == LAST);

    // Stall-cycle counter, saturating at LAST while the sequencer leaves for TRAP.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear_in || !enable_in) begin
            count_q <= '0;
        end else if (!expired_out) begin
            count_q <= count_q + CW'(1);
        end else begin
            count_q <= count_q;
        end
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer: steps FETCH/DECODE/EXECUTE/MEM/WRITEBACK,
// handshakes with both memories, traps on illegal opcodes or bus timeouts.
module multicycle_sequencer
    import multicycle_sequencer_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_WIDTH   = 64
) (
    input  logic                 clk_in,
    input  logic                 reset,
    input  logic [6:0]           opcode_in,
    input  logic                 branch_cond_in,
    input  logic                 halt_req_in,
    input  logic                 imem_ready_in,
    input  logic                 dmem_ready_in,
    output logic                 imem_req_out,
    output logic                 ir_load_en_out,
    output logic                 pc_write_en_out,
    output logic                 pc_src_out,
    output Alu_Src_t             alu_src_out,
    output Reg_Src_t             reg_src_out,
    output logic                 reg_write_en_out,
    output logic                 mem_read_en_out,
    output logic                 mem_write_en_out,
    output logic                 halted_out,
    output Trap_Cause_t          trap_cause_out,
    output logic [CNT_WIDTH-1:0] instret_out
);

    Seq_State_t           state_q;
    Op_Class_t            cls_q;
    Alu_Src_t             alu_src_q;
    Reg_Src_t             reg_src_q;
    Trap_Cause_t          trap_cause_q;
    logic [CNT_WIDTH-1:0] instret_q;

    Decode_t    dec_s;
    Seq_State_t next_fetch_s;
    logic       waiting_s;
    logic       ready_s;
    logic       expired_s;

    assign dec_s        = decode_opcode(opcode_in);
    // Halt is honoured only at instruction boundaries, i.e. on the way into FETCH.
    assign next_fetch_s = halt_req_in ? HALT : FETCH;
    assign waiting_s    = (state_q == FETCH) || (state_q == MEM);
    assign ready_s      = (state_q == FETCH) ? imem_ready_in : dmem_ready_in;

    seq_timeout_counter #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_timeout (
        .clk_in      (clk_in),
        .reset       (reset),
        .enable_in   (waiting_s && !ready_s),
        .clear_in    (!waiting_s || ready_s),
        .expired_out (expired_s)
    );

    // Sequencer state, latched decode results, trap cause and retire counter.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q      <= FETCH;
            cls_q        <= CLS_NONE;
            alu_src_q    <= ALU_SRC_REG;
            reg_src_q    <= REG_SRC_ALU;
            trap_cause_q <= TRAP_NONE;
            instret_q    <= '0;
        end else begin
            if (pc_write_en_out) begin
                instret_q <= instret_q + CNT_WIDTH'(1);
            end else begin
                instret_q <= instret_q;
            end
            case (state_q)
                FETCH: begin
                    if (imem_ready_in) begin
                        state_q <= DECODE;
                    end else if (expired_s) begin
                        state_q      <= TRAP;
                        trap_cause_q <= TRAP_TIMEOUT;
                    end else begin
                        state_q <= FETCH;
                    end
                end
                DECODE: begin
                    if (dec_s.legal) begin
                        cls_q     <= dec_s.cls;
                        alu_src_q <= dec_s.alu_src;
                        reg_src_q <= dec_s.reg_src;
                        state_q   <= EXECUTE;
                    end else begin
                        state_q      <= TRAP;
                        trap_cause_q <= TRAP_ILLEGAL;
                    end
                end
                EXECUTE: begin
                    case (cls_q)
                        CLS_R, CLS_I:         state_q <= WRITEBACK;
                        CLS_LOAD, CLS_STORE:  state_q <= MEM;
                        CLS_BRANCH:           state_q <= next_fetch_s;
                        default:              state_q <= FETCH;
                    endcase
                end
                MEM: begin
                    if (dmem_ready_in) begin
                        state_q <= (cls_q == CLS_LOAD) ? WRITEBACK : next_fetch_s;
                    end else if (expired_s) begin
                        state_q      <= TRAP;
                        trap_cause_q <= TRAP_TIMEOUT;
                    end else begin
                        state_q <= MEM;
                    end
                end
                WRITEBACK: state_q <= next_fetch_s;
                HALT:      state_q <= halt_req_in ? HALT : FETCH;
                TRAP:      state_q <= TRAP;
                default:   state_q <= FETCH;
            endcase
        end
    end

    // Moore enables from the registered state, ANDed with ready/branch where gated;
    // everything is forced to its idle value while reset is asserted.
    always_comb begin
        imem_req_out     = 1'b0;
        ir_load_en_out   = 1'b0;
        pc_write_en_out  = 1'b0;
        pc_src_out       = 1'b0;
        reg_write_en_out = 1'b0;
        mem_read_en_out  = 1'b0;
        mem_write_en_out = 1'b0;
        halted_out       = 1'b0;
        alu_src_out      = ALU_SRC_REG;
        reg_src_out      = REG_SRC_ALU;
        trap_cause_out   = TRAP_NONE;
        instret_out      = '0;
        if (reset) begin
            instret_out = '0;
        end else begin
            alu_src_out    = alu_src_q;
            reg_src_out    = reg_src_q;
            trap_cause_out = trap_cause_q;
            instret_out    = instret_q;
            case (state_q)
                FETCH: begin
                    imem_req_out   = 1'b1;
                    ir_load_en_out = imem_ready_in;
                end
                EXECUTE: begin
                    if (cls_q == CLS_BRANCH) begin
                        pc_write_en_out = 1'b1;
                        pc_src_out      = branch_cond_in;
                    end else begin
                        pc_write_en_out = 1'b0;
                    end
                end
                MEM: begin
                    mem_read_en_out  = (cls_q == CLS_LOAD);
                    mem_write_en_out = (cls_q == CLS_STORE);
                    pc_write_en_out  = (cls_q == CLS_STORE) && dmem_ready_in;
                end
                WRITEBACK: begin
                    reg_write_en_out = 1'b1;
                    pc_write_en_out  = 1'b1;
                end
                HALT, TRAP: halted_out = 1'b1;
                default:    halted_out = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench: stimulus pushes per-cycle expected control vectors, a negedge
// monitor pops and compares them against the sequencer outputs.
module tb_multicycle_sequencer;
    import multicycle_sequencer_pkg::*;

    typedef struct packed {
        logic       imem_req;
        logic       ir_load;
        logic       pc_we;
        logic       pc_src;
        logic       alu_src;
        logic       reg_src;
        logic       reg_we;
        logic       mrd;
        logic       mwr;
        logic       halted;
        logic [1:0] tc;
    } ctl_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  opcode_s;
    logic        branch_s, halt_s, imem_ready_s, dmem_ready_s;
    logic        imem_req_s, ir_load_s, pc_we_s, pc_src_s, reg_we_s, mrd_s, mwr_s, halted_s;
    Alu_Src_t    alu_src_s;
    Reg_Src_t    reg_src_s;
    Trap_Cause_t trap_s;
    logic [63:0] instret_s;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    int          exp_cyc[$];
    ctl_t        exp_ctl[$];
    logic [63:0] exp_cnt[$];
    string       exp_name[$];

    multicycle_sequencer #(.MEM_TIMEOUT(4), .CNT_WIDTH(64)) dut (
        .clk_in(clk), .reset(reset), .opcode_in(opcode_s), .branch_cond_in(branch_s),
        .halt_req_in(halt_s), .imem_ready_in(imem_ready_s), .dmem_ready_in(dmem_ready_s),
        .imem_req_out(imem_req_s), .ir_load_en_out(ir_load_s), .pc_write_en_out(pc_we_s),
        .pc_src_out(pc_src_s), .alu_src_out(alu_src_s), .reg_src_out(reg_src_s),
        .reg_write_en_out(reg_we_s), .mem_read_en_out(mrd_s), .mem_write_en_out(mwr_s),
        .halted_out(halted_s), .trap_cause_out(trap_s), .instret_out(instret_s)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic ctl_t mk(input logic rq, input logic ld, input logic pw, input logic ps,
                                input logic a, input logic r, input logic rw, input logic mr,
                                input logic mw, input logic h, input logic [1:0] tc);
        ctl_t c;
        c = '{rq, ld, pw, ps, a, r, rw, mr, mw, h, tc};
        return c;
    endfunction

    function automatic ctl_t fe(input logic ld, input logic a, input logic r);
        return mk(1'b1, ld, 1'b0, 1'b0, a, r, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    endfunction
    function automatic ctl_t idle(input logic a, input logic r);
        return mk(1'b0, 1'b0, 1'b0, 1'b0, a, r, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    endfunction
    function automatic ctl_t wb(input logic a, input logic r);
        return mk(1'b0, 1'b0, 1'b1, 1'b0, a, r, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    endfunction
    function automatic ctl_t memc(input logic rd, input logic wr, input logic pw, input logic a, input logic r);
        return mk(1'b0, 1'b0, pw, 1'b0, a, r, 1'b0, rd, wr, 1'b0, 2'b00);
    endfunction
    function automatic ctl_t hlt(input logic a, input logic r, input logic [1:0] tc);
        return mk(1'b0, 1'b0, 1'b0, 1'b0, a, r, 1'b0, 1'b0, 1'b0, 1'b1, tc);
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_at(input string nm, input int at, input ctl_t c, input logic [63:0] n);
        exp_name.push_back(nm);
        exp_cyc.push_back(at);
        exp_ctl.push_back(c);
        exp_cnt.push_back(n);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        expect_at("reset_zero", cyc, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00), 64'd0);
        tick(1);
        reset = 1'b0;
    endtask

    // Monitor: compare every expectation due in the current cycle.
    always @(negedge clk) begin
        int          at;
        ctl_t        e, act;
        logic [63:0] n;
        string       nm;
        while (exp_cyc.size() > 0 && exp_cyc[0] <= cyc) begin
            at  = exp_cyc.pop_front();
            e   = exp_ctl.pop_front();
            n   = exp_cnt.pop_front();
            nm  = exp_name.pop_front();
            act = mk(imem_req_s, ir_load_s, pc_we_s, pc_src_s, alu_src_s, reg_src_s,
                     reg_we_s, mrd_s, mwr_s, halted_s, trap_s);
            checks++;
            if (at != cyc || act !== e || instret_s !== n) begin
                errors++;
                $display("FAIL %s cyc=%0d (due %0d): ctl got %b need %b, instret got %0d need %0d",
                         nm, cyc, at, act, e, instret_s, n);
            end
        end
    end

    initial begin
        int c;
        reset = 1'b1; opcode_s = OPC_R; branch_s = 1'b0; halt_s = 1'b0;
        imem_ready_s = 1'b1; dmem_ready_s = 1'b1;
        tick(1);
        do_reset();

        // R-type, ready high
        c = cyc; opcode_s = OPC_R;
        expect_at("r_fetch", c, fe(1'b1, 1'b0, 1'b0), 64'd0);
        expect_at("r_decode", c + 1, idle(1'b0, 1'b0), 64'd0);
        expect_at("r_exec", c + 2, idle(1'b0, 1'b0), 64'd0);
        expect_at("r_wb", c + 3, wb(1'b0, 1'b0), 64'd0);
        tick(4);

        // I-ALU
        c = cyc; opcode_s = OPC_I;
        expect_at("i_fetch", c, fe(1'b1, 1'b0, 1'b0), 64'd1);
        expect_at("i_decode", c + 1, idle(1'b0, 1'b0), 64'd1);
        expect_at("i_exec", c + 2, idle(1'b1, 1'b0), 64'd1);
        expect_at("i_wb", c + 3, wb(1'b1, 1'b0), 64'd1);
        tick(4);

        // LOAD, dmem ready low 3 cycles, ready arrives on the last allowed cycle
        c = cyc; opcode_s = OPC_LOAD; dmem_ready_s = 1'b0;
        expect_at("ld_fetch", c, fe(1'b1, 1'b1, 1'b0), 64'd2);
        expect_at("ld_decode", c + 1, idle(1'b1, 1'b0), 64'd2);
        expect_at("ld_exec", c + 2, idle(1'b1, 1'b1), 64'd2);
        for (int i = 3; i <= 6; i++) expect_at("ld_mem", c + i, memc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1), 64'd2);
        expect_at("ld_wb", c + 7, wb(1'b1, 1'b1), 64'd2);
        tick(6); dmem_ready_s = 1'b1; tick(2);

        // BRANCH taken, then not taken
        c = cyc; opcode_s = OPC_BRANCH; branch_s = 1'b1;
        expect_at("br1_fetch", c, fe(1'b1, 1'b1, 1'b1), 64'd3);
        expect_at("br1_decode", c + 1, idle(1'b1, 1'b1), 64'd3);
        expect_at("br1_exec", c + 2, mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00), 64'd3);
        tick(3);
        c = cyc; branch_s = 1'b0;
        expect_at("br0_fetch", c, fe(1'b1, 1'b0, 1'b0), 64'd4);
        expect_at("br0_exec", c + 2, mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00), 64'd4);
        tick(3);

        // STORE with halt raised during EXECUTE
        c = cyc; opcode_s = OPC_STORE;
        expect_at("st_fetch", c, fe(1'b1, 1'b0, 1'b0), 64'd5);
        expect_at("st_exec", c + 2, idle(1'b1, 1'b0), 64'd5);
        expect_at("st_mem", c + 3, memc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0), 64'd5);
        for (int i = 4; i <= 6; i++) expect_at("halt", c + i, hlt(1'b1, 1'b0, 2'b00), 64'd6);
        tick(2); halt_s = 1'b1; tick(4); halt_s = 1'b0; tick(1);

        // FETCH after halt, imem ready only on the MEM_TIMEOUT-th cycle: no trap
        c = cyc; opcode_s = OPC_R; imem_ready_s = 1'b0;
        for (int i = 0; i <= 2; i++) expect_at("fetch_wait", c + i, fe(1'b0, 1'b1, 1'b0), 64'd6);
        expect_at("fetch_late_ready", c + 3, fe(1'b1, 1'b1, 1'b0), 64'd6);
        expect_at("late_exec", c + 5, idle(1'b0, 1'b0), 64'd6);
        expect_at("late_wb", c + 6, wb(1'b0, 1'b0), 64'd6);
        tick(3); imem_ready_s = 1'b1; tick(4);

        // Illegal opcode: trap holds for 20 cycles, halt_req ignored
        c = cyc; opcode_s = 7'b1111111;
        expect_at("ill_fetch", c, fe(1'b1, 1'b0, 1'b0), 64'd7);
        expect_at("ill_decode", c + 1, idle(1'b0, 1'b0), 64'd7);
        for (int i = 2; i <= 21; i++) expect_at("ill_trap", c + i, hlt(1'b0, 1'b0, 2'b01), 64'd7);
        tick(2); halt_s = 1'b1; tick(8); halt_s = 1'b0; tick(12);
        do_reset();

        // FETCH timeout after reset
        c = cyc; opcode_s = OPC_R; imem_ready_s = 1'b0;
        for (int i = 0; i <= 3; i++) expect_at("fetch_to_wait", c + i, fe(1'b0, 1'b0, 1'b0), 64'd0);
        expect_at("fetch_to_trap", c + 4, hlt(1'b0, 1'b0, 2'b10), 64'd0);
        expect_at("fetch_to_hold", c + 5, hlt(1'b0, 1'b0, 2'b10), 64'd0);
        tick(6); imem_ready_s = 1'b1;
        do_reset();

        // Reset asserted while a LOAD waits in MEM
        c = cyc; opcode_s = OPC_LOAD; dmem_ready_s = 1'b0;
        expect_at("rm_fetch", c, fe(1'b1, 1'b0, 1'b0), 64'd0);
        expect_at("rm_exec", c + 2, idle(1'b1, 1'b1), 64'd0);
        expect_at("rm_mem", c + 3, memc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1), 64'd0);
        tick(4);
        do_reset();

        // FETCH right after reset, then STORE whose dmem never answers: bus timeout
        c = cyc; opcode_s = OPC_STORE;
        expect_at("rst_mem_fetch", c, fe(1'b1, 1'b0, 1'b0), 64'd0);
        expect_at("sto_decode", c + 1, idle(1'b0, 1'b0), 64'd0);
        expect_at("sto_exec", c + 2, idle(1'b1, 1'b0), 64'd0);
        for (int i = 3; i <= 6; i++) expect_at("sto_mem_wait", c + i, memc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0), 64'd0);
        expect_at("sto_trap", c + 7, hlt(1'b1, 1'b0, 2'b10), 64'd0);
        tick(8);

        for (int i = 0; i < 20 && exp_cyc.size() > 0; i++) tick(1);
        if (exp_cyc.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_cyc.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
